// File: rtl/nibble_fifo_seg_if.sv
// nibble_fifo_seg_if: bundles the packed io_in/io_out pin groups of the nibble FIFO display block.
interface nibble_fifo_seg_if;
    logic [7:0] io_in;
    logic [7:0] io_out;
    modport master (output io_in, input io_out);
    modport slave (input io_in, output io_out);
endinterface

// File: rtl/nibble_fifo_seg.sv
// nibble_fifo_seg: push/pop pins synchronized and edge-detected into a nibble FIFO,
// head shown on a registered seven-segment output with a full flag.
module nibble_fifo_seg #(
    parameter int DEPTH = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [6:0] seg_lut [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    logic clk, rst;
    logic [SYNC_STAGES-1:0] push_s, pop_s;
    logic push_d, pop_d;
    logic push_p, pop_p, do_push, do_pop, full;
    logic [3:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    assign clk = io_in[0];
    assign rst = io_in[1];
    // When full, a simultaneous pop frees the slot the push then reuses.
    always_comb begin
        push_p = push_s[SYNC_STAGES-1] & ~push_d;
        pop_p = pop_s[SYNC_STAGES-1] & ~pop_d;
        full = count == CW'(DEPTH);
        do_pop = pop_p & (count != '0);
        do_push = push_p & (~full | pop_p);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_s <= '0;
            pop_s <= '0;
            push_d <= 1'b0;
            pop_d <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            io_out <= 8'h00;
        end else begin
            push_s <= {push_s[SYNC_STAGES-2:0], io_in[2]};
            pop_s <= {pop_s[SYNC_STAGES-2:0], io_in[3]};
            push_d <= push_s[SYNC_STAGES-1];
            pop_d <= pop_s[SYNC_STAGES-1];
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count + CW'(do_push) - CW'(do_pop);
            io_out <= {full, count != '0 ? seg_lut[mem[rd_ptr]] : 7'h00};
        end
    end
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= io_in[7:4];
endmodule

// File: doc/nibble_fifo_seg.md
NIBBLE_FIFO_SEG -- requirements
Module: nibble_fifo_seg

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set FIFO entries; power of two, 2..8.
REQ-002 Parameter SYNC_STAGES, default 2, SHALL set synchronizer flops on push/pop pins; minimum 2.
REQ-003 io_in[0]  input  1  clock; single clock domain, all state on its rising edge.
REQ-004 io_in[1]  input  1  reset; asynchronous, active-high.
REQ-005 io_in[2]  input  1  push request pin; level from switch or upstream stage, asynchronous to clock.
REQ-006 io_in[3]  input  1  pop request pin; same properties as push.
REQ-007 io_in[7:4]  input  4  data nibble; held stable by source from push rise until the write edge.
REQ-008 io_out[6:0]  output  7  seven-segment drive of FIFO head, segment a = bit 0 .. g = bit 6, active-high.
REQ-009 io_out[7]  output  1  full flag, high when count = DEPTH.
REQ-010 Ports SHALL be exactly io_in[7:0] and io_out[7:0]; clock and reset are io_in[0] and io_in[1].

Function
REQ-011 Push and pop pins SHALL each pass through SYNC_STAGES flops, then a rising-edge detector (sync output high, previous-sample flop low) producing a one-cycle pulse.
REQ-012 With SYNC_STAGES=2 and a pin first sampled high at edge E0: pulse asserted between E1 and E2, FIFO updated at E2, io_out reflects the update at E3.
REQ-013 A held-high pin SHALL produce exactly one pulse; a new pulse requires the pin to be sampled low at least one cycle.
REQ-014 Push pulse with count < DEPTH SHALL write io_in[7:4] (sampled at the write edge) at the write pointer, increment write pointer modulo DEPTH, increment count.
REQ-015 Pop pulse with count > 0 SHALL increment read pointer modulo DEPTH and decrement count; storage contents unchanged.
REQ-016 Push when full without simultaneous pop SHALL be dropped; no state change.
REQ-017 Pop when empty SHALL be ignored; no state change.
REQ-018 Simultaneous push and pop, 0 < count < DEPTH: both performed, count unchanged.
REQ-019 Simultaneous push and pop when full: pop then push in the same edge, count stays DEPTH, full stays high.
REQ-020 Simultaneous push and pop when empty: push only, count becomes 1.
REQ-021 count SHALL be clog2(DEPTH)+1 bits, range 0..DEPTH; never wraps.
REQ-022 io_out SHALL be registered, loaded every edge from next-cycle head/count state per REQ-012 timing.
REQ-023 count > 0: io_out[6:0] SHALL encode head nibble hex: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-024 count = 0: io_out[6:0] SHALL be 00 (blank).
REQ-025 io_out[7] SHALL equal (count == DEPTH), registered with io_out[6:0].

Reset
REQ-026 Reset asserted SHALL immediately clear pointers, count, synchronizer and edge-detect flops, io_out to 00, independent of clock.
REQ-027 Storage array need not be cleared; its contents SHALL never be visible while empty.
REQ-028 Reset mid-operation SHALL abort any in-flight pulse; no write or pop occurs on the deasserting edge.
REQ-029 A push/pop pin high across reset release SHALL be treated as a new rising edge and produce one pulse after SYNC_STAGES edges.

Verification
REQ-030 Reset, push 0x3 -> io_out = 0x4F at E3 after pin rise; io_out[7]=0.
REQ-031 Push 1,2,3,4 (DEPTH=4) -> io_out = 0x86 (full + '1'); fifth push 0x5 dropped; four pops show 5B, 4F, 66, then 00.
REQ-032 Pop on empty -> io_out stays 00, count 0; subsequent push 0xA -> 0x77.
REQ-033 Full FIFO {1,2,3,4}, push 0xF and pop same cycle -> io_out = 0xDB ('2' + full); later pops yield 3, 4, F.
REQ-034 Push pin held high 50 cycles -> exactly one entry written; pop/push alternated 8 times with 0..7 -> pointer wrap correct, head matches data order.
REQ-035 Assert reset between push pin rise and write edge with FIFO holding 0x9 -> io_out = 00 immediately, no write after release.
